alu_seq: RTL and testbench

- Upstream issue/writeback stage for the 8-bit ALU.
- Accepts register-based micro-instructions over a valid/ready handshake and reads operands from a 4x8 register file.
- Drives the ALU's CLK-synchronous EN/OE/OPCODE/A/B inputs, then writes ALU_OUT and CF/OF/SF/ZF back into the register file and a flag register.
- Also executes LOADI and NOP locally, without the ALU.

---
 rtl/alu_seq_if.sv | 24 ++
 rtl/alu_seq.sv | 129 ++++++++++++
 tb/tb_alu_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Instruction-issue handshake bundle feeding the ALU sequencer.
interface alu_seq_if #(
  parameter int DW = 8
);
  logic          IN_VALID;
  logic          IN_READY;
  logic [3:0]    IN_OP;
  logic [1:0]    IN_RD;
  logic [1:0]    IN_RS;
  logic [1:0]    IN_RT;
  logic [DW-1:0] IN_IMM;

  modport master (
    output IN_VALID, IN_OP, IN_RD,
    output IN_RS, IN_RT, IN_IMM,
    input  IN_READY
  );

  modport slave (
    input  IN_VALID, IN_OP, IN_RD,
    input  IN_RS, IN_RT, IN_IMM,
    output IN_READY
  );
endinterface

// File: rtl/alu_seq.sv
// Issue/writeback sequencer for the 8-bit ALU: 4-entry register file,
// one instruction in flight, IDLE -> EXEC -> WB per instruction.
module alu_seq #(
  parameter int NREG = 4,
  parameter int DW   = 8,
  parameter int CW   = 16
) (
  input  logic          CLK,
  input  logic          RST,
  alu_seq_if.slave      in_if,
  output logic          ALU_EN,
  output logic          ALU_OE,
  output logic [3:0]    ALU_OPCODE,
  output logic [DW-1:0] ALU_A,
  output logic [DW-1:0] ALU_B,
  input  logic [DW-1:0] ALU_RES,
  input  logic          ALU_CF,
  input  logic          ALU_OF,
  input  logic          ALU_SF,
  input  logic          ALU_ZF,
  output logic [3:0]    FLAGS,
  output logic          DONE,
  output logic          ERR,
  output logic [CW-1:0] RETIRED,
  input  logic [1:0]    RD_ADDR,
  output logic [DW-1:0] RD_DATA
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  localparam logic [3:0] OP_LOADI = 4'd1;

  state_t        state;
  state_t        state_nx;
  logic [DW-1:0] regs [NREG];
  logic [3:0]    op_q;
  logic [1:0]    rd_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [3:0]    flags_q;
  logic [CW-1:0] ret_q;
  logic          is_alu;
  logic          illegal;
  logic          wb_ok;

  assign is_alu  = (op_q >= 4'd2) && (op_q <= 4'd7);
  assign illegal = op_q[3];
  assign wb_ok   = (state == WB) && !illegal;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Every output is forced low while RST is high.
  always_comb begin
    state_nx        = state;
    in_if.IN_READY  = 1'b0;
    ALU_EN          = 1'b0;
    ALU_OE          = 1'b0;
    ALU_OPCODE      = '0;
    ALU_A           = '0;
    ALU_B           = '0;
    DONE            = 1'b0;
    ERR             = 1'b0;
    unique case (state)
      IDLE: begin
        in_if.IN_READY = !RST;
        if (in_if.IN_VALID) state_nx = EXEC;
      end
      EXEC: begin
        ALU_EN   = is_alu && !RST;
        state_nx = WB;
      end
      WB: begin
        DONE     = !illegal && !RST;
        ERR      = illegal && !RST;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if ((state != IDLE) && is_alu && !RST) begin
      ALU_OE     = 1'b1;
      ALU_OPCODE = op_q;
      ALU_A      = a_q;
      ALU_B      = b_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      flags_q <= '0;
      ret_q   <= '0;
    end else begin
      if ((state == IDLE) && in_if.IN_VALID) begin
        op_q  <= in_if.IN_OP;
        rd_q  <= in_if.IN_RD;
        imm_q <= in_if.IN_IMM;
        a_q   <= regs[in_if.IN_RS];
        b_q   <= regs[in_if.IN_RT];
      end
      if (wb_ok) begin
        ret_q <= ret_q + 1'b1;
        if (is_alu) begin
          regs[rd_q] <= ALU_RES;
          flags_q    <= {ALU_CF, ALU_OF, ALU_SF, ALU_ZF};
        end else if (op_q == OP_LOADI) begin
          regs[rd_q] <= imm_q;
        end
      end
    end
  end

  assign FLAGS   = RST ? '0 : flags_q;
  assign RETIRED = RST ? '0 : ret_q;
  assign RD_DATA = RST ? '0 : regs[RD_ADDR];

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural model of the ALU.
module tb_alu_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       ALU_EN, ALU_OE;
  logic [3:0] ALU_OPCODE;
  logic [7:0] ALU_A, ALU_B, ALU_RES;
  logic       ALU_CF, ALU_OF, ALU_SF, ALU_ZF;
  logic [3:0] FLAGS;
  logic       DONE, ERR;
  logic [15:0] RETIRED;
  logic [1:0] RD_ADDR = 2'd0;
  logic [7:0] RD_DATA;

  int checks = 0;
  int failures = 0;

  alu_seq_if #(.DW(8)) bus ();

  alu_seq dut (
    .CLK(CLK), .RST(RST), .in_if(bus),
    .ALU_EN(ALU_EN), .ALU_OE(ALU_OE),
    .ALU_OPCODE(ALU_OPCODE), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALU_RES(ALU_RES), .ALU_CF(ALU_CF), .ALU_OF(ALU_OF),
    .ALU_SF(ALU_SF), .ALU_ZF(ALU_ZF), .FLAGS(FLAGS),
    .DONE(DONE), .ERR(ERR), .RETIRED(RETIRED),
    .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA)
  );

  always #5 CLK = ~CLK;

  // ALU model: registers on EN, drives outputs while OE
  logic [7:0] m_res = 8'd0;
  logic [3:0] m_fl = 4'd0;
  always @(posedge CLK) begin
    logic [8:0] s;
    logic cf, of;
    cf = 1'b0; of = 1'b0; s = 9'd0;
    if (ALU_EN) begin
      case (ALU_OPCODE)
        4'd2: begin
          s = {1'b0, ALU_A} + {1'b0, ALU_B}; cf = s[8];
          of = (ALU_A[7] == ALU_B[7]) && (s[7] != ALU_A[7]);
        end
        4'd3: begin
          s = {1'b0, ALU_A} - {1'b0, ALU_B}; cf = s[8];
          of = (ALU_A[7] != ALU_B[7]) && (s[7] != ALU_A[7]);
        end
        4'd4: s = {1'b0, ALU_A & ALU_B};
        4'd5: s = {1'b0, ALU_A | ALU_B};
        4'd6: s = {1'b0, ALU_A ^ ALU_B};
        4'd7: s = {1'b0, ~ALU_A};
        default: s = 9'd0;
      endcase
      m_res <= s[7:0];
      m_fl  <= {cf, of, s[7], (s[7:0] == 8'd0)};
    end
  end
  assign ALU_RES = ALU_OE ? m_res : 8'd0;
  assign {ALU_CF, ALU_OF, ALU_SF, ALU_ZF} = ALU_OE ? m_fl : 4'd0;

  task automatic run_instr(input logic [3:0] op, input logic [1:0] rd,
                           input logic [1:0] rs, input logic [1:0] rt,
                           input logic [7:0] imm,
                           output logic done, output logic err,
                           output logic en, output logic [3:0] xop,
                           output logic [7:0] xa, output logic [7:0] xb);
    int n = 0;
    while (!bus.IN_READY && n < 20) begin
      @(negedge CLK); n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL ready_timeout got=0 exp=1");
    end
    bus.IN_OP = op; bus.IN_RD = rd; bus.IN_RS = rs;
    bus.IN_RT = rt; bus.IN_IMM = imm; bus.IN_VALID = 1'b1;
    @(negedge CLK);
    bus.IN_VALID = 1'b0;
    en = ALU_EN; xop = ALU_OPCODE; xa = ALU_A; xb = ALU_B;
    @(negedge CLK);
    done = DONE; err = ERR; en = en | ALU_EN;
    @(negedge CLK);
  endtask

  logic d, e, en;
  logic [3:0] xop;
  logic [7:0] xa, xb;

  task automatic test_reset();
    bus.IN_VALID = 1'b0; bus.IN_OP = 4'd0; bus.IN_RD = 2'd0;
    bus.IN_RS = 2'd0; bus.IN_RT = 2'd0; bus.IN_IMM = 8'd0;
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (bus.IN_READY !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", bus.IN_READY); end
    checks++; if ({DONE, ERR, ALU_EN, ALU_OE} !== 4'b0) begin failures++; $display("FAIL rst_ctl got=%b exp=0000", {DONE, ERR, ALU_EN, ALU_OE}); end
    @(negedge CLK);
    checks++; if (RETIRED !== 16'd0) begin failures++; $display("FAIL rst_retired got=%h exp=0", RETIRED); end
    checks++; if (FLAGS !== 4'd0) begin failures++; $display("FAIL rst_flags got=%b exp=0", FLAGS); end
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (bus.IN_READY !== 1'b1) begin failures++; $display("FAIL rst_ready_after got=%b exp=1", bus.IN_READY); end
    for (int i = 0; i < 4; i++) begin
      RD_ADDR = 2'(i); #1;
      checks++; if (RD_DATA !== 8'h00) begin failures++; $display("FAIL rst_reg%0d got=%h exp=00", i, RD_DATA); end
    end
  endtask

  task automatic test_loadi_add();
    int dn = 0;
    run_instr(4'd1, 2'd1, 2'd0, 2'd0, 8'h55, d, e, en, xop, xa, xb); dn += int'(d);
    checks++; if (en !== 1'b0) begin failures++; $display("FAIL loadi_en got=%b exp=0", en); end
    run_instr(4'd1, 2'd2, 2'd0, 2'd0, 8'h3C, d, e, en, xop, xa, xb); dn += int'(d);
    run_instr(4'd2, 2'd3, 2'd1, 2'd2, 8'h00, d, e, en, xop, xa, xb); dn += int'(d);
    checks++; if ({en, xop, xa, xb} !== {1'b1, 4'd2, 8'h55, 8'h3C}) begin failures++; $display("FAIL add_alu_drive got=%b/%h/%h/%h exp=1/2/55/3c", en, xop, xa, xb); end
    checks++; if (dn !== 3) begin failures++; $display("FAIL add_dones got=%0d exp=3", dn); end
    checks++; if (RETIRED !== 16'd3) begin failures++; $display("FAIL add_retired got=%h exp=0003", RETIRED); end
    checks++; if (FLAGS !== 4'b0110) begin failures++; $display("FAIL add_flags got=%b exp=0110", FLAGS); end
    RD_ADDR = 2'd3; #1;
    checks++; if (RD_DATA !== 8'h91) begin failures++; $display("FAIL add_r3 got=%h exp=91", RD_DATA); end
    checks++; if (ALU_OPCODE !== 4'd0 || ALU_OE !== 1'b0) begin failures++; $display("FAIL idle_alu got=%h/%b exp=0/0", ALU_OPCODE, ALU_OE); end
  endtask

  task automatic test_sub_not();
    run_instr(4'd3, 2'd0, 2'd1, 2'd1, 8'h00, d, e, en, xop, xa, xb);
    RD_ADDR = 2'd0; #1;
    checks++; if (RD_DATA !== 8'h00) begin failures++; $display("FAIL sub_r0 got=%h exp=00", RD_DATA); end
    checks++; if (FLAGS !== 4'b0001) begin failures++; $display("FAIL sub_flags got=%b exp=0001", FLAGS); end
    run_instr(4'd7, 2'd2, 2'd1, 2'd0, 8'h00, d, e, en, xop, xa, xb);
    RD_ADDR = 2'd2; #1;
    checks++; if (RD_DATA !== 8'hAA) begin failures++; $display("FAIL not_r2 got=%h exp=aa", RD_DATA); end
    checks++; if (FLAGS !== 4'b0010) begin failures++; $display("FAIL not_flags got=%b exp=0010", FLAGS); end
  endtask

  task automatic test_illegal();
    logic [7:0] exp_r [4];
    exp_r[0] = 8'h00; exp_r[1] = 8'h55; exp_r[2] = 8'hAA; exp_r[3] = 8'h91;
    run_instr(4'b1010, 2'd1, 2'd2, 2'd3, 8'h77, d, e, en, xop, xa, xb);
    checks++; if ({e, d, en} !== 3'b100) begin failures++; $display("FAIL illegal_err_done_en got=%b exp=100", {e, d, en}); end
    checks++; if (RETIRED !== 16'd5) begin failures++; $display("FAIL illegal_retired got=%h exp=0005", RETIRED); end
    checks++; if (FLAGS !== 4'b0010) begin failures++; $display("FAIL illegal_flags got=%b exp=0010", FLAGS); end
    for (int i = 0; i < 4; i++) begin
      RD_ADDR = 2'(i); #1;
      checks++; if (RD_DATA !== exp_r[i]) begin failures++; $display("FAIL illegal_reg%0d got=%h exp=%h", i, RD_DATA, exp_r[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] bop [4];
    logic [1:0] brd [4];
    logic [1:0] brs [4];
    logic [7:0] bimm [4];
    logic [7:0] exp_r [4];
    int hs [4];
    int idx = 0, dn = 0, ens = 0, rbad = 0;
    bop[0] = 4'd1; bop[1] = 4'd2; bop[2] = 4'd4; bop[3] = 4'd5;
    brd[0] = 2'd0; brd[1] = 2'd1; brd[2] = 2'd2; brd[3] = 2'd3;
    brs[0] = 2'd0; brs[1] = 2'd0; brs[2] = 2'd1; brs[3] = 2'd1;
    bimm[0] = 8'h07; bimm[1] = 8'h00; bimm[2] = 8'h00; bimm[3] = 8'h00;
    exp_r[0] = 8'h07; exp_r[1] = 8'h0E; exp_r[2] = 8'h06; exp_r[3] = 8'h0F;
    for (int c = 0; c < 13; c++) begin
      if (bus.IN_READY !== (c % 3 == 0)) rbad++;
      dn += int'(DONE);
      ens += int'(ALU_EN);
      if (bus.IN_READY) begin
        if (idx < 4) begin
          bus.IN_OP = bop[idx]; bus.IN_RD = brd[idx];
          bus.IN_RS = brs[idx]; bus.IN_RT = 2'd0;
          bus.IN_IMM = bimm[idx]; bus.IN_VALID = 1'b1;
          hs[idx] = c; idx++;
        end else begin
          bus.IN_VALID = 1'b0;
        end
      end
      @(negedge CLK);
    end
    checks++; if (rbad !== 0) begin failures++; $display("FAIL b2b_ready_pattern got=%0d exp=0", rbad); end
    checks++; if ({hs[1], hs[2], hs[3]} !== {32'd3, 32'd6, 32'd9}) begin failures++; $display("FAIL b2b_handshake got=%0d,%0d,%0d exp=3,6,9", hs[1], hs[2], hs[3]); end
    checks++; if (dn !== 4) begin failures++; $display("FAIL b2b_dones got=%0d exp=4", dn); end
    checks++; if (ens !== 3) begin failures++; $display("FAIL b2b_alu_en got=%0d exp=3", ens); end
    checks++; if (RETIRED !== 16'd9) begin failures++; $display("FAIL b2b_retired got=%h exp=0009", RETIRED); end
    for (int i = 0; i < 4; i++) begin
      RD_ADDR = 2'(i); #1;
      checks++; if (RD_DATA !== exp_r[i]) begin failures++; $display("FAIL b2b_reg%0d got=%h exp=%h", i, RD_DATA, exp_r[i]); end
    end
  endtask

  task automatic test_xor_hazard();
    RD_ADDR = 2'd1;
    run_instr(4'd1, 2'd1, 2'd0, 2'd0, 8'hF0, d, e, en, xop, xa, xb);
    #1;
    checks++; if (RD_DATA !== 8'hF0) begin failures++; $display("FAIL xor_loadi got=%h exp=f0", RD_DATA); end
    run_instr(4'd6, 2'd1, 2'd1, 2'd1, 8'h00, d, e, en, xop, xa, xb);
    #1;
    checks++; if (RD_DATA !== 8'h00) begin failures++; $display("FAIL xor_r1 got=%h exp=00", RD_DATA); end
    checks++; if (FLAGS !== 4'b0001) begin failures++; $display("FAIL xor_flags got=%b exp=0001", FLAGS); end
    checks++; if (RETIRED !== 16'd11) begin failures++; $display("FAIL xor_retired got=%h exp=000b", RETIRED); end
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    bus.IN_OP = 4'd2; bus.IN_RD = 2'd3; bus.IN_RS = 2'd0;
    bus.IN_RT = 2'd3; bus.IN_VALID = 1'b1;
    @(negedge CLK);
    bus.IN_VALID = 1'b0;
    RST = 1'b1;
    #1;
    checks++; if ({ALU_EN, bus.IN_READY} !== 2'b00) begin failures++; $display("FAIL mid_rst_out got=%b exp=00", {ALU_EN, bus.IN_READY}); end
    @(negedge CLK);
    RST = 1'b0;
    dn += int'(DONE);
    @(negedge CLK);
    dn += int'(DONE);
    checks++; if (dn !== 0) begin failures++; $display("FAIL mid_done got=%0d exp=0", dn); end
    checks++; if (bus.IN_READY !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", bus.IN_READY); end
    checks++; if (RETIRED !== 16'd0) begin failures++; $display("FAIL mid_retired got=%h exp=0", RETIRED); end
    for (int i = 0; i < 4; i++) begin
      RD_ADDR = 2'(i); #1;
      checks++; if (RD_DATA !== 8'h00) begin failures++; $display("FAIL mid_reg%0d got=%h exp=00", i, RD_DATA); end
    end
    run_instr(4'd1, 2'd2, 2'd0, 2'd0, 8'h5A, d, e, en, xop, xa, xb);
    RD_ADDR = 2'd2; #1;
    checks++; if (RD_DATA !== 8'h5A) begin failures++; $display("FAIL mid_loadi got=%h exp=5a", RD_DATA); end
    checks++; if ({d, RETIRED} !== {1'b1, 16'd1}) begin failures++; $display("FAIL mid_loadi_done got=%b/%h exp=1/0001", d, RETIRED); end
  endtask

  initial begin
    test_reset();
    test_loadi_add();
    test_sub_not();
    test_illegal();
    test_back_to_back();
    test_xor_hazard();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
